// File: rtl/systolic_job_scheduler.sv
// Shares one systolic controller between the instruction decoder (port 0) and
// the host/debug path (port 1): round-robin grant, start/config drive, watchdog.
module systolic_job_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [18:0] req0_desc,
  input  logic [18:0] req1_desc,
  output logic [1:0]  resp_done,
  output logic [1:0]  resp_err,
  output logic        sys_start,
  output logic [1:0]  sys_mode,
  output logic [7:0]  sys_rows,
  output logic [7:0]  sys_acc_addr,
  output logic        sys_acc_clear,
  input  logic        sys_busy,
  input  logic        sys_done,
  output logic        sched_busy,
  output logic        grant_id,
  output logic [15:0] job_count
);

  localparam int unsigned WDOG_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] rows;
    logic [7:0] acc_addr;
    logic       acc_clear;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_RUN,
    S_RESP
  } state_t;

  state_t            state;
  state_t            next_state;
  desc_t             win_desc;
  logic              win_id;
  logic              grant_ok;
  logic              timeout_hit;
  logic              rr_last;
  logic [WDOG_W-1:0] wdog_cnt;

  logic              start_d;
  logic              clear_d;
  logic              sched_busy_d;
  logic [1:0]        done_d;
  logic [1:0]        err_d;

  // Round-robin pick: on a tie the requester not served last wins
  always_comb begin
    win_id = req_valid[1];
    if (req_valid == 2'b11) begin
      win_id = ~rr_last;
    end
    win_desc  = win_id ? desc_t'(req1_desc) : desc_t'(req0_desc);
    grant_ok  = rst_n && (state == S_IDLE) && !sys_busy && (req_valid != 2'b00);
    req_ready = {grant_ok && win_id, grant_ok && !win_id};
  end

  // A done arriving on the timeout cycle still counts as success
  assign timeout_hit = (wdog_cnt == WDOG_W'(TIMEOUT_CYCLES)) && !sys_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (grant_ok) begin
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (sys_done || timeout_hit) begin
          next_state = S_RESP;
        end else if (sys_busy) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (sys_done || timeout_hit) begin
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    start_d      = 1'b0;
    clear_d      = 1'b0;
    done_d       = 2'b00;
    err_d        = 2'b00;
    sched_busy_d = (next_state != S_IDLE);
    if (state == S_IDLE && grant_ok) begin
      start_d = 1'b1;
      clear_d = win_desc.acc_clear;
    end
    if (next_state == S_RESP) begin
      if (sys_done) begin
        done_d = grant_id ? 2'b10 : 2'b01;
      end else begin
        err_d  = grant_id ? 2'b10 : 2'b01;
      end
    end
  end

  // Registered outputs, latched descriptor, watchdog and fairness state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sys_start     <= 1'b0;
      sys_acc_clear <= 1'b0;
      sys_mode      <= 2'b00;
      sys_rows      <= 8'h00;
      sys_acc_addr  <= 8'h00;
      resp_done     <= 2'b00;
      resp_err      <= 2'b00;
      sched_busy    <= 1'b0;
      grant_id      <= 1'b0;
      job_count     <= '0;
      wdog_cnt      <= '0;
      rr_last       <= 1'b1;
    end else begin
      sys_start     <= start_d;
      sys_acc_clear <= clear_d;
      resp_done     <= done_d;
      resp_err      <= err_d;
      sched_busy    <= sched_busy_d;
      if (state == S_IDLE && grant_ok) begin
        sys_mode     <= win_desc.mode;
        sys_rows     <= win_desc.rows;
        sys_acc_addr <= win_desc.acc_addr;
        grant_id     <= win_id;
      end
      if (state == S_ISSUE) begin
        wdog_cnt <= '0;
      end else if (state == S_WAIT_BUSY || state == S_RUN) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
      if (next_state == S_RESP && sys_done) begin
        job_count <= job_count + CNT_W'(1);
      end
      if (state == S_RESP) begin
        rr_last <= grant_id;
      end
    end
  end

  // Handshake and response encodings never carry more than one bit
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_resp_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0({resp_done, resp_err}));

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Bench for systolic_job_scheduler: timestamp-based job model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_systolic_job_scheduler;

  localparam int unsigned TMO = 16;
  localparam logic [18:0] HOLD_DESC = {2'b11, 8'hAA, 8'h55, 1'b0};

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [18:0] req0_desc;
  logic [18:0] req1_desc;
  logic [1:0]  resp_done;
  logic [1:0]  resp_err;
  logic        sys_start;
  logic [1:0]  sys_mode;
  logic [7:0]  sys_rows;
  logic [7:0]  sys_acc_addr;
  logic        sys_acc_clear;
  logic        sys_busy;
  logic        sys_done;
  logic        sched_busy;
  logic        grant_id;
  logic [15:0] job_count;

  systolic_job_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_desc(req0_desc), .req1_desc(req1_desc),
    .resp_done(resp_done), .resp_err(resp_err),
    .sys_start(sys_start), .sys_mode(sys_mode), .sys_rows(sys_rows),
    .sys_acc_addr(sys_acc_addr), .sys_acc_clear(sys_acc_clear),
    .sys_busy(sys_busy), .sys_done(sys_done),
    .sched_busy(sched_busy), .grant_id(grant_id), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // requester queues, controller knobs, observation logs
  logic [18:0] q0[$];
  logic [18:0] q1[$];
  bit          hold1 = 1'b0;
  int          grant_log[$];
  int          hs_log[$];
  int          ctrl_len   = 4;
  bit          ctrl_stuck = 1'b0;
  int          ctrl_age   = 0;
  int          done_cnt[2] = '{0, 0};
  int          err_cnt[2]  = '{0, 0};
  int          last_start = 0, last_sysdone = 0, last_resp = 0, last_err = 0;
  bit          last_start_clear = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [18:0] mk(input logic [1:0] m, input logic [7:0] r,
                                     input logic [7:0] a, input logic c);
    return {m, r, a, c};
  endfunction

  function automatic int glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int hlog(input int i);
    return (i < hs_log.size()) ? hs_log[i] : -1000;
  endfunction

  function automatic int total_resp();
    return done_cnt[0] + done_cnt[1] + err_cnt[0] + err_cnt[1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: hold valid and descriptor until accepted
  initial begin
    req_valid = 2'b00;
    req0_desc = '0;
    req1_desc = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          if (i == 0 && q0.size() > 0) void'(q0.pop_front());
          if (i == 1 && q1.size() > 0) void'(q1.pop_front());
        end
      end
      @(posedge clk);
      #1;
      req_valid = {1'((q1.size() > 0) || hold1), 1'(q0.size() > 0)};
      req0_desc = (q0.size() > 0) ? q0[0] : 19'h0;
      req1_desc = (q1.size() > 0) ? q1[0] : HOLD_DESC;
    end
  end

  // Controller: busy for ctrl_len-1 cycles after start, then a done pulse
  initial begin
    sys_busy = 1'b0;
    sys_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) ctrl_age = 0;
      else if (sys_start) ctrl_age = 1;
      else if (ctrl_age > 0) ctrl_age++;
      if (ctrl_age > ctrl_len && !ctrl_stuck) ctrl_age = 0;
      @(posedge clk);
      #1;
      sys_busy = (ctrl_age > 0) && (ctrl_stuck || ctrl_age < ctrl_len);
      sys_done = (ctrl_age > 0) && !ctrl_stuck && (ctrl_age == ctrl_len);
    end
  end

  // Event monitor
  initial forever begin
    @(negedge clk);
    if ((req_valid & req_ready) != 2'b00) hs_log.push_back(cyc);
    if (sys_start) begin
      last_start = cyc;
      last_start_clear = sys_acc_clear;
    end
    if (sys_done) last_sysdone = cyc;
    for (int i = 0; i < 2; i++) begin
      if (resp_done[i]) begin done_cnt[i]++; last_resp = cyc; end
      if (resp_err[i])  begin err_cnt[i]++;  last_err  = cyc; end
    end
  end

  // Job model: one job in flight, described by owner and timestamps
  bit          m_on = 1'b0, m_owner = 1'b0, m_ok = 1'b0, m_rr_last = 1'b1, m_grant = 1'b0;
  bit          m_clear = 1'b0;
  int          m_start = 0, m_resp_at = -1;
  logic [1:0]  m_mode = '0;
  logic [7:0]  m_rows = '0, m_addr = '0;
  logic [15:0] m_count = '0;

  initial forever begin
    logic [1:0]  e_ready, e_done, e_err;
    logic [18:0] wd;
    bit          w, e_start;
    @(negedge clk);
    e_ready = 2'b00;
    w = req_valid[1];
    if (req_valid == 2'b11) w = ~m_rr_last;
    if (rst_n && !m_on && !sys_busy && req_valid != 2'b00) e_ready = w ? 2'b10 : 2'b01;
    e_start = m_on && (cyc == m_start);
    e_done  = (m_on && m_resp_at == cyc && m_ok)  ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    e_err   = (m_on && m_resp_at == cyc && !m_ok) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready",     32'(req_ready),     32'(e_ready));
    chk("sys_start",     32'(sys_start),     32'(e_start));
    chk("sys_acc_clear", 32'(sys_acc_clear), 32'(e_start && m_clear));
    chk("resp_done",     32'(resp_done),     32'(e_done));
    chk("resp_err",      32'(resp_err),      32'(e_err));
    chk("sched_busy",    32'(sched_busy),    32'(m_on));
    chk("grant_id",      32'(grant_id),      32'(m_grant));
    chk("job_count",     32'(job_count),     32'(m_count));
    chk("sys_cfg",       32'({sys_mode, sys_rows, sys_acc_addr}), 32'({m_mode, m_rows, m_addr}));
    if (!rst_n) begin
      m_on = 1'b0; m_rr_last = 1'b1; m_grant = 1'b0; m_count = '0;
      m_mode = '0; m_rows = '0; m_addr = '0; m_clear = 1'b0; m_resp_at = -1;
    end else if (e_ready != 2'b00) begin
      wd = w ? req1_desc : req0_desc;
      m_on = 1'b1; m_owner = w; m_grant = w; m_start = cyc + 1; m_resp_at = -1;
      {m_mode, m_rows, m_addr, m_clear} = wd;
    end else if (m_on) begin
      if (m_resp_at == cyc) begin
        m_on = 1'b0;
        m_rr_last = m_owner;
      end else if (cyc > m_start && m_resp_at < 0) begin
        if (sys_done) begin
          m_resp_at = cyc + 1; m_ok = 1'b1; m_count = m_count + 16'd1;
        end else if (cyc - m_start - 1 == int'(TMO)) begin
          m_resp_at = cyc + 1; m_ok = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_resps(input int target, input int budget);
    int n = 0;
    while (total_resp() < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("resp_wait", 32'(total_resp()), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int base, d0, d1, e0, tr, rel, n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    chk("rst_job_count",  32'(job_count),  32'd0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    chk("rst_sys_rows",   32'(sys_rows),   32'd0);

    // single job from req0
    q0.push_back(mk(2'b00, 8'd4, 8'h10, 1'b1));
    wait_resps(1, 50);
    chk("t1_grant",     32'(glog(0)), 32'd0);
    chk("t1_start_lat", 32'(last_start - hlog(0)), 32'd1);
    chk("t1_clear",     32'(last_start_clear), 32'd1);
    chk("t1_resp_lat",  32'(last_resp - last_sysdone), 32'd1);
    tick(2);
    chk("t1_rows_held", 32'(sys_rows), 32'd4);
    chk("t1_addr_held", 32'(sys_acc_addr), 32'h10);
    chk("t1_count",     32'(job_count), 32'd1);
    chk("t1_done0",     32'(done_cnt[0]), 32'd1);

    // fairness after reset: both valid continuously
    do_reset();
    chk("t2_rst_count", 32'(job_count), 32'd0);
    chk("t2_rst_rows",  32'(sys_rows),  32'd0);
    base = grant_log.size(); d0 = done_cnt[0]; d1 = done_cnt[1]; tr = total_resp();
    q0.push_back(mk(2'b01, 8'd0,   8'h20, 1'b0));
    q0.push_back(mk(2'b10, 8'd255, 8'h21, 1'b1));
    q1.push_back(mk(2'b11, 8'd7,   8'h30, 1'b1));
    q1.push_back(mk(2'b00, 8'd128, 8'hFF, 1'b0));
    wait_resps(tr + 4, 200);
    chk("t2_g0", 32'(glog(base)),     32'd0);
    chk("t2_g1", 32'(glog(base + 1)), 32'd1);
    chk("t2_g2", 32'(glog(base + 2)), 32'd0);
    chk("t2_g3", 32'(glog(base + 3)), 32'd1);
    chk("t2_spacing", 32'(hlog(base + 1) - hlog(base)), 32'd7);
    chk("t2_done0", 32'(done_cnt[0] - d0), 32'd2);
    chk("t2_done1", 32'(done_cnt[1] - d1), 32'd2);
    chk("t2_count", 32'(job_count), 32'd4);

    // watchdog timeout with a stuck controller
    ctrl_stuck = 1'b1;
    e0 = err_cnt[0]; tr = total_resp();
    q0.push_back(mk(2'b00, 8'd9, 8'h40, 1'b0));
    wait_resps(tr + 1, 100);
    chk("t3_err_lat", 32'(last_err - last_start), 32'(TMO + 2));
    chk("t3_err0",    32'(err_cnt[0] - e0), 32'd1);
    chk("t3_count",   32'(job_count), 32'd4);
    base = grant_log.size();
    q1.push_back(mk(2'b01, 8'd3, 8'h41, 1'b0));
    tick(10);
    chk("t3_no_grant", 32'(grant_log.size()), 32'(base));
    ctrl_stuck = 1'b0;
    ctrl_age = 0;
    rel = cyc + 1;
    tr = total_resp();
    wait_resps(tr + 1, 50);
    chk("t3_regrant_lat", 32'(hlog(hs_log.size() - 1) - rel), 32'd0);
    chk("t3_regrant_id",  32'(glog(base)), 32'd1);

    // done exactly at the timeout count, then done with no busy phase
    ctrl_len = TMO + 1;
    d0 = done_cnt[0]; e0 = err_cnt[0]; tr = total_resp();
    q0.push_back(mk(2'b10, 8'd1, 8'h50, 1'b1));
    wait_resps(tr + 1, 100);
    chk("t4_done0",  32'(done_cnt[0] - d0), 32'd1);
    chk("t4_err0",   32'(err_cnt[0] - e0), 32'd0);
    chk("t4_lat",    32'(last_resp - last_start), 32'(TMO + 2));
    chk("t4_count",  32'(job_count), 32'd6);
    ctrl_len = 1;
    tr = total_resp();
    q1.push_back(mk(2'b00, 8'd2, 8'h51, 1'b0));
    wait_resps(tr + 1, 50);
    chk("t4_fast_lat", 32'(last_resp - last_start), 32'd2);

    // reset in the middle of RUN
    ctrl_len = 10;
    q0.push_back(mk(2'b01, 8'd5, 8'h60, 1'b1));
    n = 0;
    while (!(sys_busy && sched_busy) && n < 30) begin
      tick(1);
      n++;
    end
    chk("t5_in_run", 32'(sys_busy && sched_busy), 32'd1);
    tick(2);
    tr = total_resp();
    do_reset();
    chk("t5_sched_busy", 32'(sched_busy), 32'd0);
    chk("t5_cfg", 32'({sys_mode, sys_rows, sys_acc_addr, grant_id}), 32'd0);
    chk("t5_count", 32'(job_count), 32'd0);
    tick(12);
    chk("t5_no_resp", 32'(total_resp()), 32'(tr));
    ctrl_len = 4;
    base = grant_log.size();
    q0.push_back(mk(2'b11, 8'd6, 8'h70, 1'b0));
    q1.push_back(mk(2'b10, 8'd8, 8'h71, 1'b0));
    wait_resps(tr + 2, 100);
    chk("t5_tie_first", 32'(glog(base)), 32'd0);
    chk("t5_tie_second", 32'(glog(base + 1)), 32'd1);

    // req1 raised and withdrawn while a job runs
    ctrl_len = 12;
    base = grant_log.size(); d1 = done_cnt[1]; tr = total_resp();
    q0.push_back(mk(2'b00, 8'd11, 8'h80, 1'b0));
    n = 0;
    while (!sched_busy && n < 10) begin
      tick(1);
      n++;
    end
    hold1 = 1'b1;
    tick(5);
    hold1 = 1'b0;
    wait_resps(tr + 1, 50);
    tick(6);
    chk("t6_grants", 32'(grant_log.size() - base), 32'd1);
    chk("t6_resps",  32'(total_resp() - tr), 32'd1);
    chk("t6_done1",  32'(done_cnt[1] - d1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected end before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
